aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller. It owns the 128-bit state register and the round counter, and drives one shared combinational round datapath (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) once per cycle for NR rounds. It fetches round keys by index from a precomputed key store and exposes valid/ready handshakes on the plaintext input and the ciphertext output. It sits between the block-level input FIFO and the output formatter.

---
 rtl/aes_round_sequencer.sv | 103 ++++++++++
 tb/tb_aes_round_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: owns the state register and round
// counter, and steps an external combinational round datapath once per cycle.
module aes_round_sequencer #(
  parameter int NB   = 4,
  parameter int WORD = 8,
  parameter int NR   = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NB*NB*WORD-1:0]    i_block,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NB*NB*WORD-1:0]    o_block,
  output logic [3:0]               o_key_idx,
  input  logic [NB*NB*WORD-1:0]    i_round_key,
  output logic [NB*NB*WORD-1:0]    o_dp_state,
  output logic [NB*NB*WORD-1:0]    o_dp_key,
  output logic                     o_dp_final,
  input  logic [NB*NB*WORD-1:0]    i_dp_result,
  output logic                     o_busy,
  output logic [3:0]               o_round
);

  localparam int W = NB * NB * WORD;
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } st_e;

  st_e          st_q, st_d;
  logic [W-1:0] sreg_q, sreg_d;
  logic [3:0]   rnd_q, rnd_d;

  always_comb begin
    st_d       = st_q;
    sreg_d     = sreg_q;
    rnd_d      = rnd_q;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_block    = '0;
    o_key_idx  = '0;
    o_dp_final = 1'b0;
    unique case (st_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          sreg_d = i_block ^ i_round_key;
          rnd_d  = 4'd1;
          st_d   = ROUND;
        end
      end
      ROUND: begin
        o_key_idx  = rnd_q;
        o_dp_final = (rnd_q == NR_L);
        sreg_d     = i_dp_result;
        if (rnd_q == NR_L) st_d = DONE;
        else rnd_d = rnd_q + 4'd1;
      end
      DONE: begin
        o_valid = 1'b1;
        o_block = sreg_q;
        if (i_ready) begin
          st_d  = IDLE;
          rnd_d = '0;
        end
      end
      default: begin
        st_d  = IDLE;
        rnd_d = '0;
      end
    endcase
    // abort outranks every transition, including an accept this cycle
    if (i_clear) begin
      st_d   = IDLE;
      rnd_d  = '0;
      sreg_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= IDLE;
      sreg_q <= '0;
      rnd_q  <= '0;
    end else begin
      st_q   <= st_d;
      sreg_q <= sreg_d;
      rnd_q  <= rnd_d;
    end
  end

  assign o_busy     = (st_q != IDLE);
  assign o_round    = rnd_q;
  assign o_dp_state = sreg_q;
  assign o_dp_key   = i_round_key;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES datapath, key store and
// scoreboard with FIPS-197 vectors plus randomized keys/blocks.
module tb_aes_round_sequencer;
  localparam int NR = 10;

  typedef logic [10:0][127:0] rks_t;
  typedef struct {
    logic [127:0] blk;
    int           t;
  } exp_t;

  logic         i_clk, i_rst_n, i_clear, i_valid, i_ready;
  logic [127:0] i_block, i_round_key, i_dp_result;
  logic         o_ready, o_valid, o_dp_final, o_busy;
  logic [127:0] o_block, o_dp_state, o_dp_key;
  logic [3:0]   o_key_idx, o_round;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  logic prev_v = 1'b0;
  logic [127:0] last_out = '0;
  logic [127:0] cur_key = '0;
  rks_t rk_store = '0;
  exp_t sb[$];
  int   acc_q[$];

  aes_round_sequencer #(.NB(4), .WORD(8), .NR(NR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_valid(i_valid), .o_ready(o_ready), .i_block(i_block),
    .o_valid(o_valid), .i_ready(i_ready), .o_block(o_block),
    .o_key_idx(o_key_idx), .i_round_key(i_round_key),
    .o_dp_state(o_dp_state), .o_dp_key(o_dp_key),
    .o_dp_final(o_dp_final), .i_dp_result(i_dp_result),
    .o_busy(o_busy), .o_round(o_round)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= a;
      a = xt(a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // GF(2^8) inverse as x^254, then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
         ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st,
                                             input logic [127:0] key,
                                             input logic fin);
    logic [7:0] b[16];
    logic [7:0] t[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[c*4+r] = b[((c + r) % 4) * 4 + r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
        t[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ key;
  endfunction

  function automatic rks_t key_exp(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rks_t rks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]),
               sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt,
                                           input logic [127:0] key);
    rks_t rks;
    logic [127:0] s;
    rks = key_exp(key);
    s = pt ^ rks[0];
    for (int r = 1; r <= NR; r++) s = aes_round(s, rks[r], r == NR);
    return s;
  endfunction

  assign i_round_key = (o_key_idx <= 4'd10) ? rk_store[o_key_idx] : '0;
  assign i_dp_result = aes_round(o_dp_state, o_dp_key, o_dp_final);

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    cur_key = k;
    rk_store = key_exp(k);
  endtask

  // expected responses are queued at the moment a block is accepted
  always @(negedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      sb.delete();
    end else if (i_valid && o_ready) begin
      sb.push_back('{aes_enc(i_block, cur_key), cyc});
      acc_q.push_back(cyc);
    end
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_valid && !prev_v) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else chk("latency", 128'(cyc), 128'(sb[0].t + NR + 1));
    end
    if (i_rst_n && !i_clear && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("block", o_block, e.blk);
        last_out = o_block;
        out_cnt++;
      end
    end
    prev_v = o_valid;
  end

  task automatic send(input logic [127:0] blk);
    int w = 0;
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_block = blk;
    do begin
      @(negedge i_clk);
      w++;
    end while (!o_ready && w < 100);
    chk("send_accept", 128'(o_ready), 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int w = 0;
    while (out_cnt < n && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    chk("wait_out", 128'(out_cnt >= n), 1);
  endtask

  task automatic wait_valid();
    int w = 0;
    do begin
      @(negedge i_clk);
      w++;
    end while (!o_valid && w < 40);
    chk("wait_valid", 128'(o_valid), 1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int w = 0;
    do begin
      @(posedge i_clk); #1;
      w++;
    end while (o_round != r && w < 40);
    chk("wait_round", 128'(o_round), 128'(r));
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [49:0]  tr_act, tr_exp;
    logic [127:0] ref_blk;
    logic         ok, seen;
    int           d, base, n0;

    i_rst_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_block = '0;
    load_key(KEY_B);
    repeat (2) @(negedge i_clk);
    chk("reset_ctl",
        128'({o_valid, o_busy, o_round, o_key_idx, o_dp_final, o_ready}),
        128'({1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1}));
    chk("reset_block", o_block, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // App. B
    send(PT_B);
    wait_out(1);
    chk("fips_b", last_out, CT_B);

    // App. C.1 with key-index / final-round trace
    @(posedge i_clk); #1;
    load_key(KEY_C);
    send(PT_C);
    tr_act = '0; tr_exp = '0; ok = 1'b1;
    for (int k = 1; k <= NR; k++) begin
      @(negedge i_clk);
      tr_act = {tr_act[44:0], o_key_idx, o_dp_final};
      tr_exp = {tr_exp[44:0], 4'(k), 1'(k == NR)};
      ok &= (o_dp_key == i_round_key);
    end
    chk("c1_key_trace", 128'(tr_act), 128'(tr_exp));
    chk("c1_dp_key", 128'(ok), 1);
    wait_out(2);
    chk("fips_c1", last_out, CT_C);
    @(negedge i_clk);
    chk("idle_key_idx", 128'({o_key_idx, o_dp_final}), 0);

    // backpressure with i_valid held high
    @(posedge i_clk); #1;
    load_key({$urandom, $urandom, $urandom, $urandom});
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_block = {$urandom, $urandom, $urandom, $urandom};
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_block = {$urandom, $urandom, $urandom, $urandom};
    wait_valid();
    d = cyc;
    ref_blk = o_block;
    ok = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge i_clk);
      ok &= (o_block == ref_blk) && !o_ready && o_valid
          && (o_round == 4'(NR));
      if (j == 4) begin
        @(posedge i_clk); #1;
        i_ready = 1'b1;
      end
    end
    chk("bp_stable", 128'(ok), 1);
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    chk("bp_second_accept", 128'(acc_q[acc_q.size()-1]), 128'(d + 6));
    wait_out(4);

    // back-to-back
    @(posedge i_clk); #1;
    base = acc_q.size();
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int w = 0;
      i_block = {$urandom, $urandom, $urandom, $urandom};
      do begin
        @(negedge i_clk);
        w++;
      end while (!o_ready && w < 40);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    chk("b2b_count", 128'(acc_q.size() - base), 3);
    if (acc_q.size() >= base + 3) begin
      chk("b2b_gap1", 128'(acc_q[base+1] - acc_q[base]), 12);
      chk("b2b_gap2", 128'(acc_q[base+2] - acc_q[base+1]), 12);
    end
    wait_out(7);

    // clear at round 5
    send({$urandom, $urandom, $urandom, $urandom});
    wait_round(4'd5);
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    chk("clear_idle", 128'({o_ready, o_round, o_busy}), 128'({1'b1, 4'd0, 1'b0}));
    seen = 1'b0;
    repeat (15) begin
      @(negedge i_clk);
      seen |= o_valid;
    end
    chk("clear_no_valid", 128'(seen), 0);
    n0 = out_cnt;
    send({$urandom, $urandom, $urandom, $urandom});
    wait_out(n0 + 1);

    // clear coinciding with an accept
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_clear = 1'b1;
    @(negedge i_clk);
    chk("clear_accept_ready", 128'(o_ready), 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    chk("clear_accept_idle", 128'({o_busy, o_round}), 0);

    // asynchronous reset at round 7
    load_key(KEY_B);
    send(PT_B);
    wait_round(4'd7);
    #2 i_rst_n = 1'b0;
    #1 chk("async_reset", 128'({o_busy, o_round, o_valid}), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    n0 = out_cnt;
    send(PT_B);
    wait_out(n0 + 1);
    chk("fips_b_after_reset", last_out, CT_B);

    // random keys, blocks and stall lengths
    for (int n = 0; n < 12; n++) begin
      @(posedge i_clk); #1;
      load_key({$urandom, $urandom, $urandom, $urandom});
      i_ready = 1'b0;
      n0 = out_cnt;
      send({$urandom, $urandom, $urandom, $urandom});
      wait_valid();
      repeat ($urandom_range(1, 4)) @(posedge i_clk);
      #1 i_ready = 1'b1;
      wait_out(n0 + 1);
    end

    repeat (3) @(negedge i_clk);
    chk("sb_empty", 128'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
